// File: rtl/param_control_unit_pkg.sv
// ============================================================================
// cu_pkg : opcodes, FSM state codes and ALU selects for param_control_unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

  localparam logic [3:0] c_op_noop  = 4'd0;
  localparam logic [3:0] c_op_store = 4'd1;
  localparam logic [3:0] c_op_load  = 4'd2;
  localparam logic [3:0] c_op_add   = 4'd3;
  localparam logic [3:0] c_op_sub   = 4'd4;
  localparam logic [3:0] c_op_halt  = 4'd5;
  localparam logic [3:0] c_op_jmp   = 4'd6;
  localparam logic [3:0] c_op_jz    = 4'd7;

  localparam logic [2:0] c_alu_pass = 3'd0;
  localparam logic [2:0] c_alu_add  = 3'd1;
  localparam logic [2:0] c_alu_sub  = 3'd2;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_JUMP   = 4'd10,
    S_JWAIT  = 4'd11
  } cu_state_t;

endpackage

`default_nettype wire

// File: rtl/param_control_unit_if.sv
// ============================================================================
// param_control_unit_if : instruction-memory, register-file and data-memory
//                         control bundle of the control unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_control_unit_if #(
  parameter int PC_W  = 5,
  parameter int RF_AW = 4,
  parameter int DM_AW = 8
);
  localparam int IW = 4 + RF_AW + DM_AW;

  logic [PC_W-1:0]  imem_addr;
  logic [IW-1:0]    imem_data;
  logic             rf_ra_zero;
  logic [DM_AW-1:0] d_addr;
  logic             d_wr;
  logic             rf_s;
  logic [RF_AW-1:0] rf_w_addr;
  logic             rf_w_wr;
  logic [RF_AW-1:0] rf_ra_addr;
  logic             rf_ra_rd;
  logic [RF_AW-1:0] rf_rb_addr;
  logic             rf_rb_rd;
  logic [2:0]       alu_s0;
  logic [PC_W-1:0]  pc_address;
  logic [IW-1:0]    instruction;
  logic [3:0]       state_o;

  modport master (
    input  imem_data, rf_ra_zero,
    output imem_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
           rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd, alu_s0,
           pc_address, instruction, state_o
  );

  modport slave (
    output imem_data, rf_ra_zero,
    input  imem_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
           rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd, alu_s0,
           pc_address, instruction, state_o
  );

endinterface

`default_nettype wire

// File: rtl/param_control_unit_pc.sv
// ============================================================================
// cu_pc : program counter with clear, increment (wrapping) and target load
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_pc #(
  parameter int PC_W = 5
) (
  input  wire logic            clock,
  input  wire logic            reset,
  input  wire logic            i_clear,
  input  wire logic            i_up,
  input  wire logic            i_load,
  input  wire logic [PC_W-1:0] i_target,
  output logic      [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else if (i_clear) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_up) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/param_control_unit.sv
// ============================================================================
// param_control_unit : PC, instruction register and sequencing FSM
// Optional JMP/JZ support enabled by defining CU_BRANCH_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module param_control_unit
  import cu_pkg::*;
#(
  parameter int PC_W  = 5,
  parameter int RF_AW = 4,
  parameter int DM_AW = 8
) (
  input  wire logic            clock,
  input  wire logic            reset,
  param_control_unit_if.master bus
);

  localparam int IW = 4 + RF_AW + DM_AW;

  generate
    if ((2 * RF_AW > DM_AW) || (PC_W > DM_AW)) begin : g_bad_params
      $error("param_control_unit: need 2*RF_AW <= DM_AW and PC_W <= DM_AW");
    end
  endgenerate

  cu_state_t        r_state;
  cu_state_t        w_state_next;
  logic [IW-1:0]    r_ir;
  logic [PC_W-1:0]  w_pc;
  logic             w_ir_load;
  logic             w_pc_up;
  logic             w_pc_load;

  logic [DM_AW-1:0] w_d_addr;
  logic             w_d_wr;
  logic             w_rf_s;
  logic [RF_AW-1:0] w_rf_w_addr;
  logic             w_rf_w_wr;
  logic [RF_AW-1:0] w_rf_ra_addr;
  logic             w_rf_ra_rd;
  logic [RF_AW-1:0] w_rf_rb_addr;
  logic             w_rf_rb_rd;
  logic [2:0]       w_alu_s0;

  // Instruction fields; which ones are meaningful depends on the opcode
  logic [3:0]       w_opcode;
  logic [DM_AW-1:0] w_fld_hi_addr;
  logic [DM_AW-1:0] w_fld_lo_addr;
  logic [RF_AW-1:0] w_fld_ra;
  logic [RF_AW-1:0] w_fld_rb;
  logic [RF_AW-1:0] w_fld_w;
  logic [PC_W-1:0]  w_fld_target;

  assign w_opcode      = r_ir[IW-1 -: 4];
  assign w_fld_hi_addr = r_ir[IW-5 -: DM_AW];
  assign w_fld_lo_addr = r_ir[DM_AW-1:0];
  assign w_fld_ra      = r_ir[IW-5 -: RF_AW];
  assign w_fld_rb      = r_ir[IW-5-RF_AW -: RF_AW];
  assign w_fld_w       = r_ir[RF_AW-1:0];
  assign w_fld_target  = r_ir[PC_W-1:0];

  cu_pc #(
    .PC_W (PC_W)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (r_state == S_INIT),
    .i_up     (w_pc_up),
    .i_load   (w_pc_load),
    .i_target (w_fld_target),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ir_load) begin
        r_ir <= bus.imem_data;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ir_load    = 1'b0;
    w_pc_up      = 1'b0;
    w_pc_load    = 1'b0;
    w_d_addr     = '0;
    w_d_wr       = 1'b0;
    w_rf_s       = 1'b0;
    w_rf_w_addr  = '0;
    w_rf_w_wr    = 1'b0;
    w_rf_ra_addr = '0;
    w_rf_ra_rd   = 1'b0;
    w_rf_rb_addr = '0;
    w_rf_rb_rd   = 1'b0;
    w_alu_s0     = c_alu_pass;

    case (r_state)
      S_INIT: w_state_next = S_FETCH;
      S_FETCH: begin
        w_ir_load    = 1'b1;
        w_pc_up      = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_opcode)
          c_op_store: w_state_next = S_STORE;
          c_op_load:  w_state_next = S_LOAD_A;
          c_op_add:   w_state_next = S_ADD;
          c_op_sub:   w_state_next = S_SUB;
          c_op_halt:  w_state_next = S_HALT;
`ifdef CU_BRANCH_EN
          c_op_jmp,
          c_op_jz:    w_state_next = S_JUMP;
`endif
          default:    w_state_next = S_NOOP;
        endcase
      end
      S_NOOP: w_state_next = S_FETCH;
      S_LOAD_A: begin
        w_d_addr     = w_fld_hi_addr;
        w_state_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_d_addr     = w_fld_hi_addr;
        w_rf_s       = 1'b1;
        w_rf_w_addr  = w_fld_w;
        w_rf_w_wr    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_STORE: begin
        w_rf_ra_addr = w_fld_ra;
        w_rf_ra_rd   = 1'b1;
        w_d_addr     = w_fld_lo_addr;
        w_d_wr       = 1'b1;
        w_state_next = S_FETCH;
      end
      S_ADD, S_SUB: begin
        w_rf_ra_addr = w_fld_ra;
        w_rf_ra_rd   = 1'b1;
        w_rf_rb_addr = w_fld_rb;
        w_rf_rb_rd   = 1'b1;
        w_alu_s0     = (r_state == S_ADD) ? c_alu_add : c_alu_sub;
        w_rf_w_addr  = w_fld_w;
        w_rf_w_wr    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_HALT: w_state_next = S_HALT;
`ifdef CU_BRANCH_EN
      S_JUMP: begin
        if (w_opcode == c_op_jmp) begin
          w_pc_load    = 1'b1;
          w_state_next = S_JWAIT;
        end else begin
          w_rf_ra_addr = w_fld_ra;
          w_rf_ra_rd   = 1'b1;
          w_pc_load    = bus.rf_ra_zero;
          w_state_next = bus.rf_ra_zero ? S_JWAIT : S_FETCH;
        end
      end
      // Gives the synchronous instruction memory one edge to see the new PC
      S_JWAIT: w_state_next = S_FETCH;
`endif
      default: w_state_next = S_INIT;
    endcase
  end

`ifndef CU_BRANCH_EN
  logic w_unused_ra_zero;
  assign w_unused_ra_zero = bus.rf_ra_zero;
`endif

  assign bus.imem_addr   = w_pc;
  assign bus.pc_address  = w_pc;
  assign bus.instruction = r_ir;
  assign bus.state_o     = r_state;
  assign bus.d_addr      = w_d_addr;
  assign bus.d_wr        = w_d_wr;
  assign bus.rf_s        = w_rf_s;
  assign bus.rf_w_addr   = w_rf_w_addr;
  assign bus.rf_w_wr     = w_rf_w_wr;
  assign bus.rf_ra_addr  = w_rf_ra_addr;
  assign bus.rf_ra_rd    = w_rf_ra_rd;
  assign bus.rf_rb_addr  = w_rf_rb_addr;
  assign bus.rf_rb_rd    = w_rf_rb_rd;
  assign bus.alu_s0      = w_alu_s0;

endmodule

`default_nettype wire

// File: tb/tb_param_control_unit.sv
// ============================================================================
// tb_param_control_unit : directed self-checking bench for param_control_unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_control_unit;

  localparam int PC_W  = 5;
  localparam int RF_AW = 4;
  localparam int DM_AW = 8;
  localparam int IW    = 4 + RF_AW + DM_AW;

`ifdef CU_BRANCH_EN
  localparam logic [IW-1:0] c_w1 = 16'h0000;
  localparam logic [IW-1:0] c_w2 = 16'h0000;
`else
  localparam logic [IW-1:0] c_w1 = 16'h6123;
  localparam logic [IW-1:0] c_w2 = 16'h7321;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [IW-1:0] imem [0:31];
  int n_checks = 0;
  int n_pass   = 0;

  param_control_unit_if #(.PC_W(PC_W), .RF_AW(RF_AW), .DM_AW(DM_AW)) bus ();

  param_control_unit #(
    .PC_W  (PC_W),
    .RF_AW (RF_AW),
    .DM_AW (DM_AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // One-cycle synchronous instruction memory
  always @(posedge clock) bus.imem_data <= imem[bus.imem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] ctrl_now();
    return {4'd0, bus.d_addr, bus.d_wr, bus.rf_s, bus.rf_w_addr, bus.rf_w_wr,
            bus.rf_ra_addr, bus.rf_ra_rd, bus.rf_rb_addr, bus.rf_rb_rd, bus.alu_s0};
  endfunction

  // Args: d_addr, d_wr, rf_s, w_addr, w_wr, ra_addr, ra_rd, rb_addr, rb_rd, alu
  function automatic logic [31:0] ctrl_exp(input logic [7:0] da, input logic dw,
                                           input logic rs, input logic [3:0] wa,
                                           input logic ww, input logic [3:0] ra,
                                           input logic rr, input logic [3:0] rb,
                                           input logic rbr, input logic [2:0] alu);
    return {4'd0, da, dw, rs, wa, ww, ra, rr, rb, rbr, alu};
  endfunction

  task automatic wait_state_pc(input string tag, input logic [3:0] st,
                               input logic [4:0] pc, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bus.state_o == st && bus.pc_address == pc) break;
      step();
    end
    check(tag, {bus.state_o, bus.pc_address}, {st, pc});
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 32; a++) imem[a] = '0;
  endtask

  task automatic restart();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rf_ra_zero = 1'b0;
    clear_imem();
    imem[0] = 16'h2101;   // LOAD  R1 <- M[0x10]
    imem[1] = 16'h3112;   // ADD   R2 = R1 + R1
    imem[2] = 16'h1220;   // STORE M[0x20] <- R2
    imem[3] = 16'h5000;   // HALT
    @(negedge clock);
    restart();

    // Reset while ADD is executing
    wait_state_pc("run_to_add", 4'd7, 5'd2, 40);
    check("add_wr_live", bus.rf_w_wr, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_state", bus.state_o, 0);
    check("rst_pc", bus.pc_address, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_ir", bus.instruction, 0);
    check("rst_ctrl", ctrl_now(), 0);
    step();
    check("rst_hold_state", bus.state_o, 0);
    #2 reset = 1'b0;
    #1;
    check("rel_state", bus.state_o, 0);

    // Program run: LOAD, ADD, STORE, HALT
    step();
    check("e1_fetch", {bus.state_o, bus.pc_address}, {4'd1, 5'd0});
    step();
    check("e2_decode", {bus.state_o, bus.pc_address}, {4'd2, 5'd1});
    check("e2_ir", bus.instruction, 16'h2101);
    check("e2_ctrl", ctrl_now(), 0);
    step();
    check("load_a_state", bus.state_o, 4);
    check("load_a_ctrl", ctrl_now(), ctrl_exp(8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check("load_b_state", bus.state_o, 5);
    check("load_b_ctrl", ctrl_now(), ctrl_exp(8'h10, 0, 1, 4'd1, 1, 0, 0, 0, 0, 0));
    step();
    check("load_next_fetch", {bus.state_o, bus.pc_address}, {4'd1, 5'd1});
    step();
    check("add_ir", bus.instruction, 16'h3112);
    step();
    check("add_state", bus.state_o, 7);
    check("add_ctrl", ctrl_now(), ctrl_exp(8'h00, 0, 0, 4'd2, 1, 4'd1, 1, 4'd1, 1, 3'd1));
    step();
    check("add_next_fetch", {bus.state_o, bus.pc_address}, {4'd1, 5'd2});
    step();
    check("store_ir", bus.instruction, 16'h1220);
    step();
    check("store_state", bus.state_o, 6);
    check("store_ctrl", ctrl_now(), ctrl_exp(8'h20, 1, 0, 0, 0, 4'd2, 1, 0, 0, 0));
    step();
    step();
    check("halt_ir", {bus.instruction, bus.pc_address}, {16'h5000, 5'd4});
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_sticks", {bus.state_o, bus.pc_address}, {4'd9, 5'd4});
      check("halt_ctrl", ctrl_now(), 0);
    end

`ifdef CU_BRANCH_EN
    // JMP 0x1A at PC 3, then JZ R5,0x04 taken and not taken
    reset = 1'b1;
    clear_imem();
    imem[3]     = 16'h601A;
    imem[5'h1A] = 16'h7504;
    imem[4]     = 16'h7504;
    imem[5]     = 16'h5000;
    step();
    reset = 1'b0;
    wait_state_pc("jmp_fetch", 4'd1, 5'd3, 30);
    step();
    check("jmp_ir", bus.instruction, 16'h601A);
    step();
    check("jmp_jump", {bus.state_o, bus.pc_address}, {4'd10, 5'd4});
    check("jmp_ctrl", ctrl_now(), 0);
    step();
    check("jmp_jwait", {bus.state_o, bus.pc_address}, {4'd11, 5'h1A});
    step();
    check("jmp_fetch_tgt", {bus.state_o, bus.imem_addr}, {4'd1, 5'h1A});
    step();
    check("jmp_tgt_ir", bus.instruction, 16'h7504);
    bus.rf_ra_zero = 1'b1;
    step();
    check("jz_t_state", bus.state_o, 10);
    check("jz_t_ctrl", ctrl_now(), ctrl_exp(0, 0, 0, 0, 0, 4'd5, 1, 0, 0, 0));
    step();
    check("jz_t_jwait", {bus.state_o, bus.pc_address}, {4'd11, 5'd4});
    step();
    step();
    check("jz_nt_ir", {bus.instruction, bus.pc_address}, {16'h7504, 5'd5});
    bus.rf_ra_zero = 1'b0;
    step();
    check("jz_nt_ctrl", ctrl_now(), ctrl_exp(0, 0, 0, 0, 0, 4'd5, 1, 0, 0, 0));
    step();
    check("jz_nt_fetch", {bus.state_o, bus.pc_address}, {4'd1, 5'd5});
    step();
    check("jz_nt_next_ir", bus.instruction, 16'h5000);
`endif

    // Unused opcode 0xC (and 6/7 without branch support) then PC wrap
    reset = 1'b1;
    clear_imem();
    imem[0] = 16'hC5A5;
    imem[1] = c_w1;
    imem[2] = c_w2;
    bus.rf_ra_zero = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    check("op_c_ir", {bus.instruction, bus.pc_address}, {16'hC5A5, 5'd1});
    step();
    check("op_c_noop", {bus.state_o, bus.pc_address}, {4'd3, 5'd1});
    check("op_c_ctrl", ctrl_now(), 0);
    step();
    step();
    check("op_6_ir", {bus.instruction, bus.pc_address}, {c_w1, 5'd2});
    step();
    check("op_6_noop", {bus.state_o, bus.pc_address}, {4'd3, 5'd2});
    check("op_6_ctrl", ctrl_now(), 0);
    step();
    step();
    step();
    check("op_7_noop", {bus.state_o, bus.pc_address}, {4'd3, 5'd3});
    check("op_7_ctrl", ctrl_now(), 0);
    step();
    check("op_7_fetch", {bus.state_o, bus.pc_address}, {4'd1, 5'd3});

    wait_state_pc("pc31_fetch", 4'd1, 5'd31, 150);
    step();
    check("pc_wrap", {bus.state_o, bus.pc_address}, {4'd2, 5'd0});
    step();
    step();
    check("wrap_fetch_addr", {bus.state_o, bus.imem_addr}, {4'd1, 5'd0});
    step();
    check("wrap_ir", {bus.instruction, bus.pc_address}, {16'hC5A5, 5'd1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
